// File: rtl/axiu_burst_responder_if.sv
// Bundled initiator-side burst signals and SRAM read port of axiu_burst_responder.
// slave = the responder itself, master = whatever drives start and models the SRAM.
interface axiu_burst_responder_if;
    // Handshakes: axi_start is a single-cycle request sampled only in IDLE;
    // an SRAM read is accepted on a cycle where mem_en && mem_ready, and its
    // mem_rdata is valid exactly one cycle later; axi_rvalid/axi_done are
    // one-cycle pulses with no back-pressure from the initiator.
    logic        axi_start;
    logic [31:0] axi_addr;
    logic [7:0]  axi_len;
    logic [31:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_done;
    logic        axi_busy;
    logic        axi_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  axi_start, axi_addr, axi_len, mem_ready, mem_rdata,
        output axi_rdata, axi_rvalid, axi_done, axi_busy, axi_err, mem_en, mem_addr
    );

    modport master (
        output axi_start, axi_addr, axi_len, mem_ready, mem_rdata,
        input  axi_rdata, axi_rvalid, axi_done, axi_busy, axi_err, mem_en, mem_addr
    );
endinterface

// File: rtl/axiu_burst_responder.sv
// Burst read responder: turns one start pulse into len word reads from an SRAM and
// streams the words back as beats. Optional length checking: AXIU_LEN_CHECK_EN.
module axiu_burst_responder #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    axiu_burst_responder_if.slave       bus,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef AXIU_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    state_t      r_state;
    logic [7:0]  r_len;
    logic [7:0]  r_issued;
    logic [7:0]  r_beats;
    logic        r_len_bad;
    logic        r_mem_en;
    logic [31:0] r_mem_addr;
    logic        r_rvalid;
    logic [31:0] r_rdata_hold;
    logic        r_done;
    logic        r_busy;
    logic        r_err;

    logic        w_accept;
    logic        w_len_bad;
    logic [7:0]  w_issued_nxt;
    logic [7:0]  w_beats_nxt;

    assign w_accept     = r_mem_en && bus.mem_ready;
    assign w_issued_nxt = r_issued + 8'd1;
    assign w_beats_nxt  = r_beats + {7'd0, r_rvalid};
    assign w_len_bad    = LEN_CHECK && ((bus.axi_len == 8'd0) || (32'(bus.axi_len) > MAX_LEN));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_len        <= 8'd0;
            r_issued     <= 8'd0;
            r_beats      <= 8'd0;
            r_len_bad    <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_rvalid     <= 1'b0;
            r_rdata_hold <= 32'd0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            if (r_rvalid) begin
                r_rdata_hold <= bus.mem_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.axi_start) begin
                        // A rejected length runs as an empty burst so done lands in the same cycle as len=0.
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_issued   <= 8'd0;
                        r_beats    <= 8'd0;
                        r_len      <= w_len_bad ? 8'd0 : bus.axi_len;
                        r_len_bad  <= w_len_bad;
                        r_mem_addr <= {bus.axi_addr[31:2], 2'b00};
                        r_mem_en   <= !w_len_bad && (bus.axi_len != 8'd0);
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_issued   <= w_issued_nxt;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        r_rvalid   <= 1'b1;
                        r_mem_en   <= (w_issued_nxt != r_len);
                    end
                    r_beats <= w_beats_nxt;
                    if ((r_issued == r_len) && (w_beats_nxt == r_len)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= r_len_bad;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_len_bad <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM data is only valid in the beat cycle, so the beat passes it straight through.
    assign bus.axi_rdata  = r_rvalid ? bus.mem_rdata : r_rdata_hold;
    assign bus.axi_rvalid = r_rvalid;
    assign bus.axi_done   = r_done;
    assign bus.axi_busy   = r_busy;
    assign bus.axi_err    = r_err;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_addr   = r_mem_addr;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_axiu_burst_responder.sv
// Directed bench for axiu_burst_responder: SRAM model, per-cycle monitor, and
// hand-derived expected read/beat/done timing for each burst.
module tb_axiu_burst_responder;

`ifdef AXIU_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif
    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] dbg_state;

    axiu_burst_responder_if bus();

    axiu_burst_responder #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tick  = 0;
    int t0    = 0;
    int mc;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // SRAM: word valid the cycle after acceptance, junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_ready) bus.mem_rdata <= sram_word(bus.mem_addr);
        else                             bus.mem_rdata <= 32'hDEAD_BEEF;
    end

    bit          log_en = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] stall_addr_q[$];
    logic [31:0] beat_q[$];
    int          beat_cyc_q[$];
    int          done_cyc_q[$];
    logic        err_at_done;
    int          busy_cnt, busy_first, busy_last;

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete(); stall_addr_q.delete();
        beat_q.delete(); beat_cyc_q.delete(); done_cyc_q.delete();
        err_at_done = 1'b0; busy_cnt = 0; busy_first = -1; busy_last = -1;
    endtask

    always @(negedge clk) begin
        if (log_en) begin
            mc = tick - t0;
            if (bus.mem_en && bus.mem_ready) begin
                rd_addr_q.push_back(bus.mem_addr);
                rd_cyc_q.push_back(mc);
            end
            if (bus.mem_en && !bus.mem_ready) stall_addr_q.push_back(bus.mem_addr);
            if (bus.axi_rvalid) begin
                beat_q.push_back(bus.axi_rdata);
                beat_cyc_q.push_back(mc);
                last_rdata = bus.axi_rdata;
            end else begin
                check("rdata_hold", bus.axi_rdata, last_rdata);
            end
            check("done_vs_rvalid", {31'd0, bus.axi_rvalid && bus.axi_done}, 32'd0);
            if (bus.axi_done) begin
                done_cyc_q.push_back(mc);
                err_at_done = bus.axi_err;
            end
            if (bus.axi_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = mc;
                busy_last = mc;
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_rvalid"}, {31'd0, bus.axi_rvalid}, 32'd0);
        check({tag, "_done"},   {31'd0, bus.axi_done},   32'd0);
        check({tag, "_busy"},   {31'd0, bus.axi_busy},   32'd0);
        check({tag, "_err"},    {31'd0, bus.axi_err},    32'd0);
        check({tag, "_mem_en"}, {31'd0, bus.mem_en},     32'd0);
        check({tag, "_state"},  {30'd0, dbg_state},      32'd0);
    endtask

    // Start in cycle 0; stall cycles slo..shi drop mem_ready; xs = cycle of a stray start (-1: none).
    task automatic run_burst(input logic [31:0] addr, input int len, input int slo, input int shi, input int xs);
        logic [31:0] base;
        logic [31:0] ea[$];
        logic [31:0] es[$];
        int          ec[$];
        int          elen, c, k, budget, done_exp;
        bit          bad, done_seen;
        base   = {addr[31:2], 2'b00};
        bad    = LEN_CHK && ((len == 0) || (len > MAX_LEN));
        elen   = bad ? 0 : len;
        budget = 2 * len + 20;

        @(posedge clk); #1;
        t0 = tick;
        clear_logs();
        log_en = 1'b1;
        bus.axi_start = 1'b1;
        bus.axi_addr  = addr;
        bus.axi_len   = 8'(len);
        bus.mem_ready = 1'b1;
        done_seen = 1'b0;
        c = 0;
        while (!done_seen && c < budget) begin
            @(negedge clk); #1;
            if (bus.axi_done) done_seen = 1'b1;
            if (!done_seen) begin
                @(posedge clk); #1;
                c = tick - t0;
                bus.axi_start = (c == xs);
                bus.axi_addr  = 32'hAAAA_0000;
                bus.axi_len   = 8'd9;
                bus.mem_ready = !(c >= slo && c <= shi);
            end
        end
        log_en = 1'b0;
        bus.axi_start = 1'b0;
        bus.mem_ready = 1'b1;
        check("done_seen", {31'd0, done_seen}, 32'd1);

        c = 1; k = 0;
        while (k < elen) begin
            if (c >= slo && c <= shi) begin
                es.push_back(base + 32'(4 * k));
            end else begin
                ea.push_back(base + 32'(4 * k));
                ec.push_back(c);
                k++;
            end
            c++;
        end
        done_exp = (elen == 0) ? 2 : ec[ec.size() - 1] + 2;

        check("n_reads", rd_addr_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < rd_addr_q.size(); i++) begin
            check("rd_addr", rd_addr_q[i], ea[i]);
            check("rd_cyc", rd_cyc_q[i], ec[i]);
        end
        check("n_beats", beat_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < beat_q.size(); i++) begin
            check("beat_data", beat_q[i], sram_word(ea[i]));
            check("beat_cyc", beat_cyc_q[i], ec[i] + 1);
        end
        check("n_stall", stall_addr_q.size(), es.size());
        for (int i = 0; i < es.size() && i < stall_addr_q.size(); i++)
            check("stall_addr", stall_addr_q[i], es[i]);
        check("n_done", done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) check("done_cyc", done_cyc_q[0], done_exp);
        check("err", {31'd0, err_at_done}, {31'd0, bad});
        check("busy_cnt", busy_cnt, done_exp);
        check("busy_first", busy_first, 1);
        check("busy_last", busy_last, done_exp);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("idle");
        check("idle_rdata", bus.axi_rdata, last_rdata);
    endtask

    task automatic reset_mid_burst();
        @(posedge clk); #1;
        t0 = tick;
        clear_logs();
        log_en = 1'b1;
        bus.axi_start = 1'b1;
        bus.axi_addr  = 32'h0000_0500;
        bus.axi_len   = 8'd4;
        bus.mem_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            bus.axi_start = 1'b0;
            if (c == 3) resetn = 1'b0;
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        last_rdata = 32'd0;
        @(negedge clk);
        check_quiet("rst_mid");
        check("rst_mid_rdata", bus.axi_rdata, 32'd0);
        repeat (8) @(posedge clk);
        @(negedge clk); #1;
        log_en = 1'b0;
        check("rst_mid_beats", beat_q.size(), 2);
        check("rst_mid_ndone", done_cyc_q.size(), 0);
        check("rst_mid_busy", busy_cnt, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.axi_start = 1'b0;
        bus.axi_addr  = 32'd0;
        bus.axi_len   = 8'd0;
        bus.mem_ready = 1'b1;
        resetn        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_rdata", bus.axi_rdata, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_burst(32'h0000_0104, 4, 100, 0, -1);
        idle_check();
        run_burst(32'h0000_0104, 4, 2, 3, -1);
        run_burst(32'hFFFF_FFF8, 4, 100, 0, -1);
        idle_check();
        run_burst(32'h0000_0104, 4, 100, 0, 3);
        run_burst(32'h0000_0200, 2, 100, 0, -1);
        run_burst(32'h0000_0040, 0, 100, 0, -1);
        run_burst(32'h0000_1000, 17, 5, 6, -1);
        run_burst(32'h0000_0003, 1, 100, 0, -1);
        run_burst(32'h0000_0600, 16, 100, 0, -1);
        idle_check();
        reset_mid_burst();
        run_burst(32'h0000_0080, 3, 1, 1, -1);
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
